sipo_word_receiver: RTL and testbench

Downstream stage of the team's 4-bit PISO shift register. It samples the MSB-first serial bit stream, reassembles WIDTH-bit words, and buffers them in a small show-ahead FIFO. It presents the words to the consumer over a valid/ready handshake. Frame resync and overflow detection let the link recover from dropped or misaligned bits.

---
 rtl/piso_link_pkg.sv | 20 ++
 rtl/sync_fifo_sa.sv | 68 ++++++
 rtl/sipo_word_receiver.sv | 83 ++++++++
 tb/tb_sipo_word_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/piso_link_pkg.sv
// Shared definitions for the serial word link (upstream PISO and the
// downstream SIPO receiver).
//   WORD_W     : default bits per serial word, common to both ends.
//   FIFO_DEPTH : default receive FIFO depth.
//   lvl_w()    : width of a 0..depth occupancy counter.
//   cnt_w()    : width of a 0..width-1 bit counter.
package piso_link_pkg;

    parameter int WORD_W     = 4;
    parameter int FIFO_DEPTH = 4;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO.
//   clk, rst : clock, synchronous active-high reset (clears pointers/level).
//   push/din : write din when not full, or when full and popping the same edge.
//   pop      : remove head when not empty.
//   dout     : head entry, forced to zero while empty.
//   full, empty, level : occupancy status (level is 0..DEPTH).
module sync_fifo_sa
    import piso_link_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [lvl_w(DEPTH)-1:0]    level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    assign pop_ok  = pop && !empty;
    // When full, wr_ptr == rd_ptr: the incoming word overwrites the slot
    // being popped on the same edge, so ordering is preserved.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-in word receiver: assembles MSB-first bits into WIDTH-bit words and
// queues them in a show-ahead FIFO with a valid/ready output.
//   clk, rst    : clock, synchronous active-high reset.
//   sin         : serial data bit, sampled when sin_valid=1.
//   sin_valid   : bit qualifier; idle cycles hold all state.
//   frame_start : with sin_valid, restarts assembly with this bit as MSB.
//   m_data      : FIFO head word (zero while empty).
//   m_valid     : FIFO not empty.
//   m_ready     : consumer accepts the head this cycle.
//   fifo_level  : number of stored words (0..DEPTH).
//   overflow    : sticky, set when a completed word is dropped on a full FIFO.
module sipo_word_receiver
    import piso_link_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [lvl_w(DEPTH)-1:0]    fifo_level,
    output logic                       overflow
);

    localparam int CNT_W = cnt_w(WIDTH);

    // Only the WIDTH-1 earlier bits need storing; the LSB is taken straight
    // from sin on the completing edge.
    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             fifo_full;
    logic             fifo_empty;

    assign word_done = sin_valid && !frame_start && (bit_cnt == CNT_W'(WIDTH - 1));
    assign word      = {sr, sin};
    assign m_valid   = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (sin_valid) begin
                if (frame_start) begin
                    sr      <= (WIDTH-1)'(sin);
                    bit_cnt <= CNT_W'(1);
                end else begin
                    sr      <= (WIDTH-1)'({sr, sin});
                    bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                end
            end
            // Full implies non-empty, so m_ready alone decides whether a pop
            // frees a slot on this edge.
            if (word_done && fifo_full && !m_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo_sa #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_done),
        .din   (word),
        .pop   (m_ready),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Scoreboard bench for sipo_word_receiver: stimulus pushes expected words,
// a negedge monitor pops and compares each word the consumer accepts.
module tb_sipo_word_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [2:0]   fifo_level;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    sipo_word_receiver #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .frame_start (frame_start),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at negedge is the pop on the next posedge.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", m_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", m_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs, input int gap);
        sin         = b;
        sin_valid   = 1'b1;
        frame_start = fs;
        tick();
        sin_valid   = 1'b0;
        frame_start = 1'b0;
        repeat (gap) tick();
    endtask

    // gap_mode=1 inserts 0..3 idle cycles after bits (not after the LSB).
    task automatic send_word(input logic [W-1:0] w, input logic fs, input int gap_mode);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], fs && (i == W - 1), (gap_mode != 0 && i != 0) ? i % 4 : 0);
        end
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!m_valid && exp_q.size() == 0) break;
            tick();
        end
        m_ready = 1'b0;
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_valid_after"}, int'(m_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_data", int'(m_data), 0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        do_reset();

        // 1: single word, consumer stalled
        send_word(4'hD, 1'b1, 0);
        exp_q.push_back(4'hD);
        chk("t1_valid", int'(m_valid), 1);
        chk("t1_data", int'(m_data), 4'hD);
        chk("t1_level", int'(fifo_level), 1);
        drain("t1");

        // 2: back-to-back words with gaps, consumer always ready
        m_ready = 1'b1;
        exp_q.push_back(4'hD);
        send_word(4'hD, 1'b0, 1);
        exp_q.push_back(4'hA);
        send_word(4'hA, 1'b0, 1);
        drain("t2");
        chk("t2_overflow", int'(overflow), 0);

        // 3: overflow on fifth word
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_word(W'(i), 1'b1, 0);
            if (i <= 4) exp_q.push_back(W'(i));
        end
        chk("t3_level", int'(fifo_level), 4);
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_head", int'(m_data), 1);
        drain("t3");
        chk("t3_overflow_sticky", int'(overflow), 1);

        do_reset();

        // 4: resync discards partial word
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_word(4'hA, 1'b1, 0);
        exp_q.push_back(4'hA);
        chk("t4_level", int'(fifo_level), 1);
        chk("t4_data", int'(m_data), 4'hA);
        drain("t4");

        // 5: push and pop on the same edge while full
        for (int i = 1; i <= 4; i++) begin
            send_word(W'(i), 1'b1, 0);
            exp_q.push_back(W'(i));
        end
        chk("t5_full_level", int'(fifo_level), 4);
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        m_ready = 1'b1;
        exp_q.push_back(4'h7);
        send_bit(1'b1, 1'b0, 0);
        m_ready = 1'b0;
        chk("t5_level", int'(fifo_level), 4);
        chk("t5_overflow", int'(overflow), 0);
        chk("t5_head", int'(m_data), 2);
        drain("t5");

        // 6: reset mid-word with two words stored
        send_word(4'h5, 1'b1, 0);
        send_word(4'h6, 1'b1, 0);
        chk("t6_level_pre", int'(fifo_level), 2);
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        do_reset();
        send_word(4'hC, 1'b1, 0);
        exp_q.push_back(4'hC);
        chk("t6_level", int'(fifo_level), 1);
        chk("t6_data", int'(m_data), 4'hC);
        drain("t6");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
